// File: rtl/spi_cmd_loader.sv
// SPI flash-programming command parser: 0x01 + 4-byte address, 0x02 + 4-byte data word, MSB first.
// Latency: the write request is presented the cycle after the 4th data byte arrives.
// Backpressure: rx has none; a data word completing while a write is still pending is dropped and flagged.
module spi_cmd_loader #(
  parameter logic [7:0] CMD_ADDR = 8'h01,
  parameter logic [7:0] CMD_DATA = 8'h02,
  parameter int         TIMEOUT  = 65536
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_byte,
  input  logic        rx_valid,
  output logic        wr_valid,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  input  logic        wr_ready,
  input  logic        err_clr,
  output logic        err_opcode,
  output logic        err_overrun,
  output logic        err_timeout,
  output logic        busy
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;

  state_t         state_q, state_d;
  logic [1:0]     byte_cnt_q, byte_cnt_d;
  logic [23:0]    shift_q, shift_d;
  logic [31:0]    addr_reg_q, addr_reg_d;
  logic [CW-1:0]  idle_cnt_q, idle_cnt_d;
  logic           wr_valid_q, wr_valid_d;
  logic [31:0]    wr_addr_q, wr_addr_d;
  logic [31:0]    wr_data_q, wr_data_d;
  logic           err_op_q, err_op_d;
  logic           err_ov_q, err_ov_d;
  logic           err_to_q, err_to_d;

  logic           in_cmd;
  logic           last_byte;
  logic           timeout_hit;
  logic [31:0]    word;

  assign in_cmd      = (state_q != S_IDLE);
  assign last_byte   = in_cmd && rx_valid && (byte_cnt_q == 2'd3);
  assign timeout_hit = in_cmd && !rx_valid && (idle_cnt_q == TO_LAST);
  assign word        = {shift_q, rx_byte};

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      byte_cnt_q <= '0;
      shift_q    <= '0;
      addr_reg_q <= '0;
      idle_cnt_q <= '0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      err_op_q   <= 1'b0;
      err_ov_q   <= 1'b0;
      err_to_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      shift_q    <= shift_d;
      addr_reg_q <= addr_reg_d;
      idle_cnt_q <= idle_cnt_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      err_op_q   <= err_op_d;
      err_ov_q   <= err_ov_d;
      err_to_q   <= err_to_d;
    end
  end

  // Next-state: opcode dispatch from IDLE, return after 4 payload bytes or on inter-byte timeout
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (rx_valid && rx_byte == CMD_ADDR)      state_d = S_ADDR;
        else if (rx_valid && rx_byte == CMD_DATA) state_d = S_DATA;
      end
      S_ADDR, S_DATA: begin
        if (last_byte || timeout_hit) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values: byte assembly, idle counter, write request and sticky errors
  always_comb begin
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;
    addr_reg_d = addr_reg_q;
    idle_cnt_d = idle_cnt_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    // an accepted request drops unless a new word reloads it below
    wr_valid_d = wr_valid_q && !wr_ready;
    err_op_d   = err_op_q && !err_clr;
    err_ov_d   = err_ov_q && !err_clr;
    err_to_d   = err_to_q && !err_clr;

    if (!in_cmd) begin
      byte_cnt_d = '0;
      idle_cnt_d = '0;
      if (rx_valid && rx_byte != CMD_ADDR && rx_byte != CMD_DATA) err_op_d = 1'b1;
    end else if (rx_valid) begin
      idle_cnt_d = '0;
      byte_cnt_d = byte_cnt_q + 2'd1;
      shift_d    = {shift_q[15:0], rx_byte};
      if (last_byte && state_q == S_ADDR) begin
        addr_reg_d = word;
      end else if (last_byte && state_q == S_DATA) begin
        if (!wr_valid_q || wr_ready) begin
          wr_valid_d = 1'b1;
          wr_addr_d  = addr_reg_q;
          wr_data_d  = word;
          addr_reg_d = addr_reg_q + 32'd4;
        end else begin
          err_ov_d = 1'b1;
        end
      end
    end else if (timeout_hit) begin
      idle_cnt_d = '0;
      byte_cnt_d = '0;
      shift_d    = '0;
      err_to_d   = 1'b1;
    end else begin
      idle_cnt_d = idle_cnt_q + 1'b1;
    end
  end

  assign wr_valid    = wr_valid_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign err_opcode  = err_op_q;
  assign err_overrun = err_ov_q;
  assign err_timeout = err_to_q;
  assign busy        = in_cmd || wr_valid_q;

endmodule

// File: tb/tb_spi_cmd_loader.sv
// Bench for spi_cmd_loader: directed table, hand-written corner sequences, random stream vs reference model.
// Latency: outputs sampled on the falling edge after the rising edge that consumed the inputs.
// Backpressure: wr_ready is driven directly by the bench (fixed or randomised).
module tb_spi_cmd_loader;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic        wr_valid;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        wr_ready;
  logic        err_clr;
  logic        err_opcode;
  logic        err_overrun;
  logic        err_timeout;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  spi_cmd_loader #(.CMD_ADDR(8'h01), .CMD_DATA(8'h02), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .rx_byte(rx_byte), .rx_valid(rx_valid),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .err_clr(err_clr), .err_opcode(err_opcode), .err_overrun(err_overrun),
    .err_timeout(err_timeout), .busy(busy)
  );

  always #5 clk = ~clk;

  // ---------------- reference model (command-level view) ----------------
  typedef struct {
    int          mode;      // 0 none, 1 collecting address, 2 collecting data
    int          nbytes;    // payload bytes collected so far
    logic [31:0] acc;       // payload assembled arithmetically
    int          gap;       // consecutive byte-less cycles inside a command
    logic [31:0] areg;
    logic        pend;
    logic [31:0] paddr;
    logic [31:0] pdata;
    logic        e_op, e_ov, e_to;
  } model_t;

  model_t m;
  logic   started = 1'b0;

  function automatic model_t model_step(model_t cur, logic rst, logic v, logic [7:0] b,
                                        logic rdy, logic clr);
    model_t n;
    logic ev_op, ev_ov, ev_to;
    n = cur;
    ev_op = 0; ev_ov = 0; ev_to = 0;
    if (!rst) begin
      n.mode = 0; n.nbytes = 0; n.acc = 0; n.gap = 0; n.areg = 0;
      n.pend = 0; n.paddr = 0; n.pdata = 0; n.e_op = 0; n.e_ov = 0; n.e_to = 0;
      return n;
    end
    if (cur.pend && rdy) n.pend = 0;
    if (cur.mode == 0) begin
      n.gap = 0;
      if (v) begin
        if (b == 8'h01)      begin n.mode = 1; n.nbytes = 0; n.acc = 0; end
        else if (b == 8'h02) begin n.mode = 2; n.nbytes = 0; n.acc = 0; end
        else ev_op = 1;
      end
    end else if (v) begin
      n.gap = 0;
      n.acc = cur.acc * 256 + {24'd0, b};
      n.nbytes = cur.nbytes + 1;
      if (n.nbytes == 4) begin
        if (cur.mode == 1) n.areg = n.acc;
        else if (!cur.pend || rdy) begin
          n.pend = 1; n.paddr = cur.areg; n.pdata = n.acc; n.areg = cur.areg + 4;
        end else ev_ov = 1;
        n.mode = 0; n.nbytes = 0;
      end
    end else begin
      n.gap = cur.gap + 1;
      if (n.gap == TO) begin
        n.mode = 0; n.nbytes = 0; n.gap = 0; ev_to = 1;
      end
    end
    n.e_op = (cur.e_op & ~clr) | ev_op;
    n.e_ov = (cur.e_ov & ~clr) | ev_ov;
    n.e_to = (cur.e_to & ~clr) | ev_to;
    return n;
  endfunction

  // model advances on the same edge as the DUT
  always @(posedge clk) begin
    m       <= model_step(m, rst_n, rx_valid, rx_byte, wr_ready, err_clr);
    started <= 1'b1;
  end

  // every cycle: all outputs against the model
  always @(negedge clk) begin
    if (started) begin
      logic [68:0] act, exp;
      act = {wr_valid, wr_addr, wr_data, err_opcode, err_overrun, err_timeout, busy};
      exp = {m.pend, m.paddr, m.pdata, m.e_op, m.e_ov, m.e_to, (m.mode != 0) || m.pend};
      checks++;
      if (act !== exp) begin
        failures++;
        $display("FAIL model t=%0t: got vld/addr/data/err/busy %b %h %h %b %b want %b %h %h %b %b",
                 $time, act[68], act[67:36], act[35:4], act[3:1], act[0],
                 exp[68], exp[67:36], exp[35:4], exp[3:1], exp[0]);
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic cyc(input logic v, input logic [7:0] b, input logic r, input logic c);
    rx_valid = v; rx_byte = b; wr_ready = r; err_clr = c;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc(0, 8'h00, 1, 0);
    rst_n = 1'b1;
  endtask

  task automatic send_cmd(input logic [7:0] op, input logic [31:0] w, input logic r);
    cyc(1, op, r, 0);
    for (int i = 3; i >= 0; i--) cyc(1, w[8*i +: 8], r, 0);
  endtask

  task automatic chk_wr(input string nm, input logic v, input logic [31:0] a, input logic [31:0] d);
    chk({nm, ".vld"}, {31'd0, wr_valid}, {31'd0, v});
    chk({nm, ".addr"}, wr_addr, a);
    chk({nm, ".data"}, wr_data, d);
  endtask

  task automatic rcyc(input logic v, input logic [7:0] b);
    cyc(v, b, ($urandom_range(0, 9) < 7), ($urandom_range(0, 31) == 0));
  endtask

  task automatic rgap();
    if ($urandom_range(0, 9) == 0) begin
      int g = $urandom_range(1, 3);
      for (int k = 0; k < g; k++) rcyc(0, 8'h00);
    end
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic        rxv;
    logic [7:0]  rxb;
    logic        rdy;
    logic        clr;
    logic        e_wv;
    logic [31:0] e_addr;
    logic [31:0] e_data;
    logic        e_busy;
    logic [2:0]  e_err;   // {opcode, overrun, timeout}
  } vec_t;

  vec_t tbl[24];

  function automatic vec_t mk(logic v, logic [7:0] b, logic r, logic c, logic wv,
                              logic [31:0] a, logic [31:0] d, logic bz, logic [2:0] e);
    vec_t x;
    x.rxv = v; x.rxb = b; x.rdy = r; x.clr = c; x.e_wv = wv;
    x.e_addr = a; x.e_data = d; x.e_busy = bz; x.e_err = e;
    return x;
  endfunction

  initial begin
    // basic address + data write, then a bad opcode followed by a normal command
    tbl[0]  = mk(1, 8'h01, 1, 0, 0, 32'h0, 32'h0, 1, 3'b000);
    tbl[1]  = mk(1, 8'h10, 1, 0, 0, 32'h0, 32'h0, 1, 3'b000);
    tbl[2]  = mk(1, 8'h00, 1, 0, 0, 32'h0, 32'h0, 1, 3'b000);
    tbl[3]  = mk(1, 8'h00, 1, 0, 0, 32'h0, 32'h0, 1, 3'b000);
    tbl[4]  = mk(1, 8'h00, 1, 0, 0, 32'h0, 32'h0, 0, 3'b000);
    tbl[5]  = mk(1, 8'h02, 1, 0, 0, 32'h0, 32'h0, 1, 3'b000);
    tbl[6]  = mk(1, 8'hDE, 1, 0, 0, 32'h0, 32'h0, 1, 3'b000);
    tbl[7]  = mk(1, 8'hAD, 1, 0, 0, 32'h0, 32'h0, 1, 3'b000);
    tbl[8]  = mk(1, 8'hBE, 1, 0, 0, 32'h0, 32'h0, 1, 3'b000);
    tbl[9]  = mk(1, 8'hEF, 1, 0, 1, 32'h1000_0000, 32'hDEAD_BEEF, 1, 3'b000);
    tbl[10] = mk(0, 8'h00, 1, 0, 0, 32'h1000_0000, 32'hDEAD_BEEF, 0, 3'b000);
    tbl[11] = mk(1, 8'h7F, 1, 0, 0, 32'h1000_0000, 32'hDEAD_BEEF, 0, 3'b100);
    tbl[12] = mk(1, 8'h01, 1, 0, 0, 32'h1000_0000, 32'hDEAD_BEEF, 1, 3'b100);
    tbl[13] = mk(1, 8'h20, 1, 0, 0, 32'h1000_0000, 32'hDEAD_BEEF, 1, 3'b100);
    tbl[14] = mk(1, 8'h00, 1, 0, 0, 32'h1000_0000, 32'hDEAD_BEEF, 1, 3'b100);
    tbl[15] = mk(1, 8'h00, 1, 0, 0, 32'h1000_0000, 32'hDEAD_BEEF, 1, 3'b100);
    tbl[16] = mk(1, 8'h00, 1, 0, 0, 32'h1000_0000, 32'hDEAD_BEEF, 0, 3'b100);
    tbl[17] = mk(0, 8'h00, 1, 1, 0, 32'h1000_0000, 32'hDEAD_BEEF, 0, 3'b000);
    tbl[18] = mk(1, 8'h02, 1, 0, 0, 32'h1000_0000, 32'hDEAD_BEEF, 1, 3'b000);
    tbl[19] = mk(1, 8'h12, 1, 0, 0, 32'h1000_0000, 32'hDEAD_BEEF, 1, 3'b000);
    tbl[20] = mk(1, 8'h34, 1, 0, 0, 32'h1000_0000, 32'hDEAD_BEEF, 1, 3'b000);
    tbl[21] = mk(1, 8'h56, 1, 0, 0, 32'h1000_0000, 32'hDEAD_BEEF, 1, 3'b000);
    tbl[22] = mk(1, 8'h78, 1, 0, 1, 32'h2000_0000, 32'h1234_5678, 1, 3'b000);
    tbl[23] = mk(0, 8'h00, 1, 0, 0, 32'h2000_0000, 32'h1234_5678, 0, 3'b000);

    rst_n = 1'b0; rx_valid = 1'b0; rx_byte = 8'h00; wr_ready = 1'b0; err_clr = 1'b0;
    @(negedge clk);
    cyc(0, 8'h00, 0, 0);
    cyc(0, 8'h00, 0, 0);
    rst_n = 1'b1;

    // reset state
    chk_wr("reset", 0, 32'h0, 32'h0);
    chk("reset.err", {29'd0, err_opcode, err_overrun, err_timeout}, 32'h0);
    chk("reset.busy", {31'd0, busy}, 32'h0);

    for (int i = 0; i < 24; i++) begin
      cyc(tbl[i].rxv, tbl[i].rxb, tbl[i].rdy, tbl[i].clr);
      chk($sformatf("tbl%0d.vld", i), {31'd0, wr_valid}, {31'd0, tbl[i].e_wv});
      chk($sformatf("tbl%0d.addr", i), wr_addr, tbl[i].e_addr);
      chk($sformatf("tbl%0d.data", i), wr_data, tbl[i].e_data);
      chk($sformatf("tbl%0d.busy", i), {31'd0, busy}, {31'd0, tbl[i].e_busy});
      chk($sformatf("tbl%0d.err", i), {29'd0, err_opcode, err_overrun, err_timeout},
          {29'd0, tbl[i].e_err});
    end

    // address auto-increment and 32-bit wrap
    send_cmd(8'h01, 32'h1000_4000, 1);
    send_cmd(8'h02, 32'h0000_0011, 1);
    chk_wr("inc0", 1, 32'h1000_4000, 32'h0000_0011);
    send_cmd(8'h02, 32'h0000_0022, 1);
    chk_wr("inc1", 1, 32'h1000_4004, 32'h0000_0022);
    send_cmd(8'h01, 32'hFFFF_FFFC, 1);
    send_cmd(8'h02, 32'h0000_0033, 1);
    chk_wr("wrap0", 1, 32'hFFFF_FFFC, 32'h0000_0033);
    send_cmd(8'h02, 32'h0000_0044, 1);
    chk_wr("wrap1", 1, 32'h0000_0000, 32'h0000_0044);
    cyc(0, 8'h00, 1, 0);

    // overrun: word B completes while A still pending
    send_cmd(8'h01, 32'h2000_0000, 0);
    send_cmd(8'h02, 32'hAAAA_0001, 0);
    chk_wr("ovr.a", 1, 32'h2000_0000, 32'hAAAA_0001);
    send_cmd(8'h02, 32'hBBBB_0002, 0);
    chk_wr("ovr.hold", 1, 32'h2000_0000, 32'hAAAA_0001);
    chk("ovr.flag", {31'd0, err_overrun}, 32'd1);
    cyc(0, 8'h00, 1, 0);
    chk("ovr.acc", {31'd0, wr_valid}, 32'd0);
    send_cmd(8'h02, 32'hCCCC_0003, 1);
    chk_wr("ovr.next", 1, 32'h2000_0004, 32'hCCCC_0003);
    cyc(0, 8'h00, 1, 1);
    chk("ovr.clr", {31'd0, err_overrun}, 32'd0);

    // timeout on a partial address command
    do_reset();
    cyc(1, 8'h01, 1, 0);
    cyc(1, 8'h12, 1, 0);
    cyc(1, 8'h34, 1, 0);
    for (int k = 0; k < 20; k++) cyc(0, 8'h00, 1, 0);
    chk("to.flag", {31'd0, err_timeout}, 32'd1);
    chk("to.busy", {31'd0, busy}, 32'd0);
    send_cmd(8'h02, 32'h5566_7788, 1);
    chk_wr("to.wr", 1, 32'h0000_0000, 32'h5566_7788);
    cyc(0, 8'h00, 1, 1);

    // reset mid-command drops everything
    do_reset();
    cyc(1, 8'h02, 1, 0);
    cyc(1, 8'hAA, 1, 0);
    cyc(1, 8'hBB, 1, 0);
    do_reset();
    chk_wr("rst.mid", 0, 32'h0, 32'h0);
    chk("rst.busy", {31'd0, busy}, 32'd0);
    chk("rst.err", {29'd0, err_opcode, err_overrun, err_timeout}, 32'h0);
    send_cmd(8'h01, 32'h1000_0000, 1);
    send_cmd(8'h02, 32'hDEAD_BEEF, 1);
    chk_wr("rst.after", 1, 32'h1000_0000, 32'hDEAD_BEEF);
    cyc(0, 8'h00, 1, 0);
    chk("rst.pulse", {31'd0, wr_valid}, 32'd0);

    // random command stream, checked every cycle against the model
    for (int n = 0; n < 400; n++) begin
      int r = $urandom_range(0, 99);
      if (r < 40 || r < 70) begin
        logic [7:0]  op = (r < 40) ? 8'h02 : 8'h01;
        logic [31:0] w  = $urandom;
        if (r >= 40 && $urandom_range(0, 3) == 0) w = 32'hFFFF_FFF8;
        rcyc(1, op);
        for (int i = 3; i >= 0; i--) begin
          rgap();
          rcyc(1, w[8*i +: 8]);
        end
      end else if (r < 78) begin
        logic [7:0] b = 8'($urandom_range(3, 255));
        rcyc(1, b);
      end else if (r < 82) begin
        int nb = $urandom_range(0, 3);
        rcyc(1, ($urandom_range(0, 1) == 0) ? 8'h01 : 8'h02);
        for (int i = 0; i < nb; i++) rcyc(1, 8'($urandom));
        for (int k = 0; k < TO + 3; k++) rcyc(0, 8'h00);
      end else if (r < 85) begin
        do_reset();
      end else begin
        int g = $urandom_range(0, 3);
        for (int k = 0; k < g; k++) rcyc(0, 8'h00);
      end
    end
    cyc(0, 8'h00, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
